pe_operand_feeder: RTL and testbench

Operand sequencer for the float16 convolution processing element (processingElement16). It accepts one complete window of pixels and weights (WEIGHT_LENGTH×WEIGHT_WIDTH pairs) through a valid/ready handshake. It streams the pairs into the PE one per cycle with conv_en asserted, waits for the PE's out_valid, and returns the accumulated result downstream through a second valid/ready handshake. It drives the PE's operand/enable interface and consumes its result interface.

---
 rtl/pe_operand_feeder.sv | 168 ++++++++++++++++
 tb/tb_pe_operand_feeder.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_operand_feeder.sv
// Operand sequencer for the float16 convolution processing element.
// Accepts one window of N pixel/weight pairs, streams them to the PE one
// pair per cycle with conv_en high, waits (bounded) for the PE result and
// offers that result downstream through a valid/ready handshake.
module pe_operand_feeder #(
  parameter int DATA_WIDTH    = 16,
  parameter int WEIGHT_LENGTH = 3,
  parameter int WEIGHT_WIDTH  = 3,
  parameter int TIMEOUT       = 64
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              win_valid,
  output logic                                              win_ready,
  input  logic [WEIGHT_LENGTH*WEIGHT_WIDTH*DATA_WIDTH-1:0]  win_data,
  input  logic [WEIGHT_LENGTH*WEIGHT_WIDTH*DATA_WIDTH-1:0]  weight_data,
  output logic [DATA_WIDTH-1:0]                             floatA,
  output logic [DATA_WIDTH-1:0]                             floatB,
  output logic                                              conv_en,
  input  logic [DATA_WIDTH-1:0]                             pe_result,
  input  logic                                              pe_out_valid,
  output logic [DATA_WIDTH-1:0]                             res_data,
  output logic                                              res_valid,
  input  logic                                              res_ready,
  output logic                                              timeout_err
);

  localparam int N      = WEIGHT_LENGTH * WEIGHT_WIDTH;
  localparam int IDX_W  = $clog2(N + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t              state, state_d;
  logic [IDX_W-1:0]    idx, idx_d;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_d, wait_inc;
  logic                win_ready_d, conv_en_d, res_valid_d, timeout_err_d;
  logic [DATA_WIDTH-1:0] float_a_d, float_b_d, res_data_d;

  // Latched window operands; element 0 is presented straight from the inputs.
  logic [DATA_WIDTH-1:0] pix_q [N];
  logic [DATA_WIDTH-1:0] wgt_q [N];

  logic accept;
  assign accept = (state == S_IDLE) && win_valid;

  // Saturating increment of the PE response wait counter.
  assign wait_inc = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;

  // Capture the whole window on acceptance; held untouched until the next one.
  // NOTE: operand storage has no reset -- it is only ever read after a load,
  // and leaving it out of reset keeps it plain flops without a reset tree.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < N; i++) begin
        pix_q[i] <= win_data[i*DATA_WIDTH +: DATA_WIDTH];
        wgt_q[i] <= weight_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state and next-output decode for the IDLE/STREAM/WAIT/HOLD sequence.
  // NOTE: every target is given its hold value first so no path through the
  // case statement leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d       = state;
    idx_d         = idx;
    wait_cnt_d    = wait_cnt;
    win_ready_d   = win_ready;
    conv_en_d     = conv_en;
    float_a_d     = floatA;
    float_b_d     = floatB;
    res_valid_d   = res_valid;
    res_data_d    = res_data;
    timeout_err_d = timeout_err;

    unique case (state)
      S_IDLE: begin
        win_ready_d = 1'b1;
        if (win_valid) begin
          win_ready_d = 1'b0;
          conv_en_d   = 1'b1;
          float_a_d   = win_data[DATA_WIDTH-1:0];
          float_b_d   = weight_data[DATA_WIDTH-1:0];
          idx_d       = IDX_W'(1);
          state_d     = S_STREAM;
        end
      end

      S_STREAM: begin
        if (idx == IDX_LAST) begin
          // Last pair has had its cycle; idle the PE operand bus.
          conv_en_d  = 1'b0;
          float_a_d  = '0;
          float_b_d  = '0;
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end else begin
          float_a_d = pix_q[idx];
          float_b_d = wgt_q[idx];
          idx_d     = idx + 1'b1;
        end
      end

      S_WAIT: begin
        wait_cnt_d = wait_inc;
        if (pe_out_valid) begin
          res_data_d  = pe_result;
          res_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else if (wait_inc == WAIT_MAX) begin
          // PE never answered: flag it, drop the window, accept the next one.
          timeout_err_d = 1'b1;
          win_ready_d   = 1'b1;
          state_d       = S_IDLE;
        end
      end

      S_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          win_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and all registered outputs; reset drops conv_en at once.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      wait_cnt    <= '0;
      win_ready   <= 1'b1;
      conv_en     <= 1'b0;
      floatA      <= '0;
      floatB      <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      wait_cnt    <= wait_cnt_d;
      win_ready   <= win_ready_d;
      conv_en     <= conv_en_d;
      floatA      <= float_a_d;
      floatB      <= float_b_d;
      res_valid   <= res_valid_d;
      res_data    <= res_data_d;
      timeout_err <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Self-checking bench for pe_operand_feeder. A behavioural PE accumulates the
// operand pairs it is fed (as real numbers) and answers after a programmable
// latency; expected results come from a real-arithmetic dot product of the
// window that was offered.
module tb_pe_operand_feeder;

  localparam int DW  = 16;
  localparam int WL  = 3;
  localparam int WW  = 3;
  localparam int N   = WL * WW;
  localparam int TMO = 8;

  typedef logic [DW-1:0] win_t [N];

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            win_valid = 1'b0;
  logic            win_ready;
  logic [N*DW-1:0] win_data = '0;
  logic [N*DW-1:0] weight_data = '0;
  logic [DW-1:0]   floatA, floatB;
  logic            conv_en;
  logic [DW-1:0]   pe_result = '0;
  logic            pe_out_valid = 1'b0;
  logic [DW-1:0]   res_data;
  logic            res_valid;
  logic            res_ready = 1'b1;
  logic            timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pe_operand_feeder #(
    .DATA_WIDTH(DW), .WEIGHT_LENGTH(WL), .WEIGHT_WIDTH(WW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_data(win_data), .weight_data(weight_data),
    .floatA(floatA), .floatB(floatB), .conv_en(conv_en),
    .pe_result(pe_result), .pe_out_valid(pe_out_valid),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .timeout_err(timeout_err)
  );

  // ---------------- half-precision helpers ----------------
  function automatic real half_to_real(input logic [15:0] h);
    real v;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) v = real'(h[9:0]) / 16777216.0;
    else begin
      v = 1.0 + real'(h[9:0]) / 1024.0;
      for (int k = 15; k < e; k++) v = v * 2.0;
      for (int k = e; k < 15; k++) v = v / 2.0;
    end
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] real_to_half(input real x);
    real  v;
    int   e;
    int   m;
    logic s;
    if (x == 0.0) return 16'h0000;
    s = (x < 0.0);
    v = s ? -x : x;
    e = 15;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0)  begin v = v * 2.0; e--; end
    m = int'((v - 1.0) * 1024.0);
    return {s, e[4:0], m[9:0]};
  endfunction

  function automatic logic [N*DW-1:0] pack(input win_t a);
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = a[i];
    return r;
  endfunction

  // Reference: dot product of the offered window.
  function automatic logic [15:0] model_result(input win_t p, input win_t w);
    real s;
    s = 0.0;
    for (int i = 0; i < N; i++) s = s + half_to_real(p[i]) * half_to_real(w[i]);
    return real_to_half(s);
  endfunction

  // ---------------- behavioural PE ----------------
  int  pe_latency = 2;
  bit  pe_mute    = 1'b0;
  bit  pe_extra   = 1'b0;
  real pe_acc     = 0.0;
  bit  pe_busy    = 1'b0;
  int  pe_cnt     = 0;

  // Accumulates pairs while conv_en is high, answers pe_latency cycles later.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pe_acc       = 0.0;
      pe_busy      = 1'b0;
      pe_cnt       = 0;
      pe_out_valid <= 1'b0;
    end else begin
      pe_out_valid <= 1'b0;
      if (conv_en) begin
        pe_acc  = pe_acc + half_to_real(floatA) * half_to_real(floatB);
        pe_busy = 1'b1;
        pe_cnt  = 0;
      end else if (pe_busy) begin
        if (pe_cnt == pe_latency) begin
          if (!pe_mute) begin
            pe_out_valid <= 1'b1;
            pe_result    <= real_to_half(pe_acc);
          end
          pe_busy = 1'b0;
          pe_acc  = 0.0;
        end else pe_cnt++;
      end
      if (pe_extra) begin
        pe_out_valid <= 1'b1;
        pe_result    <= 16'hDEAD;
      end
    end
  end

  // ---------------- checking tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic offer(input win_t p, input win_t w);
    win_data    = pack(p);
    weight_data = pack(w);
    win_valid   = 1'b1;
  endtask

  // Called at the negedge of the first conv_en cycle; checks cnt pairs and,
  // for a full window, that the operand bus idles right after the last one.
  task automatic check_stream(input win_t p, input win_t w, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      check($sformatf("conv_en_%0d", i), conv_en, 1);
      check($sformatf("operands_%0d", i), {floatA, floatB}, {p[i], w[i]});
      check("win_ready_stream", win_ready, 0);
      if (i < cnt - 1) @(negedge clk);
    end
    if (cnt == N) begin
      @(negedge clk);
      check("conv_en_drop", conv_en, 0);
      check("operands_idle", {floatA, floatB}, 32'h0);
    end
  endtask

  task automatic wait_result(input logic [15:0] exp);
    int waited;
    waited = 0;
    while (!res_valid && waited < 40) begin
      check("win_ready_wait", win_ready, 0);
      @(negedge clk);
      waited++;
    end
    check("res_valid_seen", res_valid, 1);
    check("res_data", res_data, exp);
    check("win_ready_hold", win_ready, 0);
  endtask

  // res_ready is high: the result is accepted at the next edge.
  task automatic finish_handshake();
    @(negedge clk);
    check("res_valid_drop", res_valid, 0);
    check("win_ready_back", win_ready, 1);
  endtask

  task automatic run_window(input win_t p, input win_t w, input logic [15:0] exp);
    offer(p, w);
    check("win_ready_idle", win_ready, 1);
    @(negedge clk);
    win_valid = 1'b0;
    check_stream(p, w, N);
    wait_result(exp);
    finish_handshake();
  endtask

  task automatic rand_win(output win_t a);
    for (int i = 0; i < N; i++) a[i] = real_to_half(real'($urandom_range(0, 7)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    win_t ones, twos, ramp, unit, p1, w1, p2, w2;
    logic [15:0] exp1, exp2;

    for (int i = 0; i < N; i++) begin
      ones[i] = 16'h3C00;
      twos[i] = 16'h4000;
      unit[i] = 16'h3C00;
    end
    ramp = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500,
             16'h4600, 16'h4700, 16'h4800, 16'h4880};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_win_ready", win_ready, 1);
    check("rst_conv_en", conv_en, 0);
    check("rst_operands", {floatA, floatB}, 32'h0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 16'h0);
    check("rst_timeout_err", timeout_err, 0);
    reset = 1'b1;
    @(negedge clk);

    // Basic window: nine 1.0*2.0 products = 18.0
    run_window(ones, twos, 16'h4C80);

    // Ordering: 1.0..9.0 against unit weights, 1+2+...+9 = 45.0 = 16'h51A0
    run_window(ramp, unit, 16'h51A0);

    // Back-pressure: result held for 10 cycles with stray PE pulses and offers
    rand_win(p1); rand_win(w1); rand_win(p2); rand_win(w2);
    exp1 = model_result(p1, w1);
    res_ready = 1'b0;
    offer(p1, w1);
    @(negedge clk);
    win_valid = 1'b0;
    check_stream(p1, w1, N);
    wait_result(exp1);
    for (int c = 0; c < 10; c++) begin
      offer(p2, w2);
      pe_extra = (c == 2 || c == 5);
      @(negedge clk);
      check("bp_res_valid", res_valid, 1);
      check("bp_res_data", res_data, exp1);
      check("bp_win_ready", win_ready, 0);
      check("bp_conv_en", conv_en, 0);
    end
    pe_extra  = 1'b0;
    win_valid = 1'b0;
    res_ready = 1'b1;
    finish_handshake();
    run_window(p2, w2, model_result(p2, w2));

    // Timeout: PE stays silent, error flags exactly TMO cycles after WAIT entry
    pe_mute = 1'b1;
    offer(p1, w1);
    @(negedge clk);
    win_valid = 1'b0;
    check_stream(p1, w1, N);
    for (int k = 0; k < TMO; k++) begin
      check("tmo_err_early", timeout_err, 0);
      check("tmo_win_ready", win_ready, 0);
      check("tmo_res_valid", res_valid, 0);
      @(negedge clk);
    end
    check("tmo_err_set", timeout_err, 1);
    check("tmo_win_ready_back", win_ready, 1);
    check("tmo_no_result", res_valid, 0);
    pe_mute = 1'b0;
    run_window(p2, w2, model_result(p2, w2));
    check("tmo_err_sticky", timeout_err, 1);

    // Reset during the 5th conv_en cycle
    offer(ones, twos);
    @(negedge clk);
    win_valid = 1'b0;
    check_stream(ones, twos, 5);
    #2 reset = 1'b0;
    #1;
    check("arst_conv_en", conv_en, 0);
    check("arst_operands", {floatA, floatB}, 32'h0);
    check("arst_res_valid", res_valid, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("arst_win_ready", win_ready, 1);
    check("arst_timeout_clr", timeout_err, 0);
    @(negedge clk);
    run_window(ones, twos, 16'h4C80);

    // Back-to-back: win_valid held with a second window queued behind the first
    rand_win(p1); rand_win(w1); rand_win(p2); rand_win(w2);
    exp1 = model_result(p1, w1);
    exp2 = model_result(p2, w2);
    offer(p1, w1);
    check("b2b_win_ready", win_ready, 1);
    @(negedge clk);
    offer(p2, w2);
    check_stream(p1, w1, N);
    wait_result(exp1);
    finish_handshake();
    @(negedge clk);
    win_valid = 1'b0;
    check_stream(p2, w2, N);
    wait_result(exp2);
    finish_handshake();

    // Random windows with random PE latency
    for (int r = 0; r < 4; r++) begin
      rand_win(p1); rand_win(w1);
      pe_latency = int'($urandom_range(0, 4));
      run_window(p1, w1, model_result(p1, w1));
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
